// File: rtl/id_stage_reg_if.sv
// -----------------------------------------------------------------------------
// id_stage_pkg / id_stage_reg_if
//
// Purpose
//   id_stage_pkg holds the ALU control encodings shared by the decode and
//   execute stages (EXE_*_OP on the 8-bit ALU-op bus, EXE_RES_* on the 3-bit
//   result-select bus) together with the MIPS opcode and funct values that
//   the ID stage recognises.
//   id_stage_reg_if bundles every non-clock/reset signal of the ID stage.
//
// Modports
//   master : the ID stage itself (id_stage_reg).
//   slave  : the surrounding pipeline (IF/ID register, regfile, EX/MEM
//            bypass sources, hazard/flush control, EX stage).
//
// Signal summary (direction seen from the master)
//   in  valid_i, pc_i[31:0], inst_i[31:0]         instruction from IF/ID
//   in  reg1_data_i, reg2_data_i [DW]             regfile read data
//   out reg1_read_o, reg2_read_o, reg*_addr_o[5]  regfile read port (comb)
//   in  ex_wreg_i, ex_wd_i, ex_wdata_i, ex_is_load_i   EX writeback info
//   in  mem_wreg_i, mem_wd_i, mem_wdata_i              MEM writeback info
//   in  flush_i                                   kill instruction in ID
//   out stall_req_o                               hold IF/ID (comb)
//   out ex_* fields                               registered ID/EX state
//   out stall_cnt_o[CNTW]                         bubble-cycle counter
// -----------------------------------------------------------------------------
package id_stage_pkg;

  typedef logic [7:0] alu_op_t;
  typedef logic [2:0] alu_sel_t;

  localparam alu_op_t  EXE_NOP_OP = 8'b0000_0000;
  localparam alu_op_t  EXE_AND_OP = 8'b0010_0100;
  localparam alu_op_t  EXE_OR_OP  = 8'b0010_0101;
  localparam alu_op_t  EXE_XOR_OP = 8'b0010_0110;
  localparam alu_op_t  EXE_NOR_OP = 8'b0010_0111;
  localparam alu_op_t  EXE_LW_OP  = 8'b1110_0011;

  localparam alu_sel_t EXE_RES_NOP        = 3'b000;
  localparam alu_sel_t EXE_RES_LOGIC      = 3'b001;
  localparam alu_sel_t EXE_RES_LOAD_STORE = 3'b111;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_ANDI    = 6'b001100;
  localparam logic [5:0] OP_ORI     = 6'b001101;
  localparam logic [5:0] OP_XORI    = 6'b001110;
  localparam logic [5:0] OP_LUI     = 6'b001111;
  localparam logic [5:0] OP_LW      = 6'b100011;

  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_NOR = 6'b100111;

endpackage

interface id_stage_reg_if #(
  parameter int DW   = 32,
  parameter int CNTW = 16
);
  import id_stage_pkg::*;

  // IF/ID
  logic          valid_i;
  logic [31:0]   pc_i;
  logic [31:0]   inst_i;

  // regfile read port
  logic [DW-1:0] reg1_data_i;
  logic [DW-1:0] reg2_data_i;
  logic          reg1_read_o;
  logic          reg2_read_o;
  logic [4:0]    reg1_addr_o;
  logic [4:0]    reg2_addr_o;

  // bypass sources
  logic          ex_wreg_i;
  logic [4:0]    ex_wd_i;
  logic [DW-1:0] ex_wdata_i;
  logic          ex_is_load_i;
  logic          mem_wreg_i;
  logic [4:0]    mem_wd_i;
  logic [DW-1:0] mem_wdata_i;

  // hazard control
  logic          flush_i;
  logic          stall_req_o;

  // ID/EX register
  logic          ex_valid_o;
  logic          ex_wreg_o;
  logic          ex_is_load_o;
  logic          ex_instvalid_o;
  alu_op_t       ex_aluop_o;
  alu_sel_t      ex_alusel_o;
  logic [DW-1:0] ex_reg1_o;
  logic [DW-1:0] ex_reg2_o;
  logic [4:0]    ex_wd_o;
  logic [31:0]   ex_pc_o;

  logic [CNTW-1:0] stall_cnt_o;

  modport master (
    input  valid_i, pc_i, inst_i, reg1_data_i, reg2_data_i,
           ex_wreg_i, ex_wd_i, ex_wdata_i, ex_is_load_i,
           mem_wreg_i, mem_wd_i, mem_wdata_i, flush_i,
    output reg1_read_o, reg2_read_o, reg1_addr_o, reg2_addr_o, stall_req_o,
           ex_valid_o, ex_wreg_o, ex_is_load_o, ex_instvalid_o,
           ex_aluop_o, ex_alusel_o, ex_reg1_o, ex_reg2_o, ex_wd_o, ex_pc_o,
           stall_cnt_o
  );

  modport slave (
    output valid_i, pc_i, inst_i, reg1_data_i, reg2_data_i,
           ex_wreg_i, ex_wd_i, ex_wdata_i, ex_is_load_i,
           mem_wreg_i, mem_wd_i, mem_wdata_i, flush_i,
    input  reg1_read_o, reg2_read_o, reg1_addr_o, reg2_addr_o, stall_req_o,
           ex_valid_o, ex_wreg_o, ex_is_load_o, ex_instvalid_o,
           ex_aluop_o, ex_alusel_o, ex_reg1_o, ex_reg2_o, ex_wd_o, ex_pc_o,
           stall_cnt_o
  );

endinterface

// File: rtl/id_stage_reg.sv
// -----------------------------------------------------------------------------
// id_stage_reg
//
// Purpose
//   Instruction-decode stage of a 5-stage MIPS pipeline with its ID/EX
//   pipeline register. Decodes ORI/ANDI/XORI/LUI/LW and SPECIAL
//   AND/OR/XOR/NOR, drives the regfile read port, resolves operands through
//   the EX and MEM bypass paths, detects load-use hazards (stall + bubble)
//   and counts every bubble cycle it inserts for a hazard.
//
// Parameters
//   DW   : operand width (>= 32)
//   CNTW : width of the saturating stall counter
//
// Ports
//   clk  : rising-edge clock
//   rst  : synchronous, active-high reset
//   bus  : id_stage_reg_if.master (see interface header for signal list)
//
// Configuration macro
//   ID_MEM_FWD_EN : defined   -> MEM-stage results are forwarded to operands.
//                   undefined -> a MEM-stage match (not shadowed by EX) stalls
//                                one cycle and the operand is taken from the
//                                write-through regfile on the retry.
// -----------------------------------------------------------------------------
module id_stage_reg #(
  parameter int DW   = 32,
  parameter int CNTW = 16
) (
  input  logic           clk,
  input  logic           rst,
  id_stage_reg_if.master bus
);
  import id_stage_pkg::*;

  // Everything the EX stage sees, registered as one unit.
  typedef struct packed {
    logic          valid;
    logic          wreg;
    logic          is_load;
    logic          instvalid;
    alu_op_t       aluop;
    alu_sel_t      alusel;
    logic [DW-1:0] reg1;
    logic [DW-1:0] reg2;
    logic [4:0]    wd;
    logic [31:0]   pc;
  } id_ex_t;

  // A bubble is a harmless NOP: nothing written, instvalid kept high so the
  // EX stage never raises a reserved-instruction condition for it.
  function automatic id_ex_t bubble();
    id_ex_t b;
    b           = '0;
    b.instvalid = 1'b1;
    b.aluop     = EXE_NOP_OP;
    b.alusel    = EXE_RES_NOP;
    return b;
  endfunction

  // ---------------------------------------------------------------------------
  // Instruction fields
  // ---------------------------------------------------------------------------
  logic [5:0]  op;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [5:0]  funct;
  logic [15:0] imm16;

  assign op    = bus.inst_i[31:26];
  assign rs    = bus.inst_i[25:21];
  assign rt    = bus.inst_i[20:16];
  assign rd    = bus.inst_i[15:11];
  assign shamt = bus.inst_i[10:6];
  assign funct = bus.inst_i[5:0];
  assign imm16 = bus.inst_i[15:0];

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  logic          dec_rd1;
  logic          dec_rd2;
  logic          dec_wreg;
  logic          dec_is_load;
  logic          dec_instvalid;
  alu_op_t       dec_aluop;
  alu_sel_t      dec_alusel;
  logic [4:0]    dec_wd;
  logic [DW-1:0] dec_imm;

  // NOTE: every variable written here gets a default before the case so no
  // path leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    dec_rd1       = 1'b0;
    dec_rd2       = 1'b0;
    dec_wreg      = 1'b0;
    dec_is_load   = 1'b0;
    dec_instvalid = 1'b0;
    dec_aluop     = EXE_NOP_OP;
    dec_alusel    = EXE_RES_NOP;
    dec_wd        = 5'd0;
    dec_imm       = DW'(imm16);

    case (op)
      OP_SPECIAL: begin
        // The logical R-type ops are only defined with a zero shift field.
        if (shamt == 5'd0) begin
          case (funct)
            FN_AND: begin dec_aluop = EXE_AND_OP; dec_instvalid = 1'b1; end
            FN_OR:  begin dec_aluop = EXE_OR_OP;  dec_instvalid = 1'b1; end
            FN_XOR: begin dec_aluop = EXE_XOR_OP; dec_instvalid = 1'b1; end
            FN_NOR: begin dec_aluop = EXE_NOR_OP; dec_instvalid = 1'b1; end
            default: ;
          endcase
          if (dec_instvalid) begin
            dec_rd1    = 1'b1;
            dec_rd2    = 1'b1;
            dec_wreg   = 1'b1;
            dec_alusel = EXE_RES_LOGIC;
            dec_wd     = rd;
          end
        end
      end
      OP_ORI, OP_ANDI, OP_XORI: begin
        dec_rd1       = 1'b1;
        dec_wreg      = 1'b1;
        dec_instvalid = 1'b1;
        dec_alusel    = EXE_RES_LOGIC;
        dec_wd        = rt;
        if (op == OP_ORI)       dec_aluop = EXE_OR_OP;
        else if (op == OP_ANDI) dec_aluop = EXE_AND_OP;
        else                    dec_aluop = EXE_XOR_OP;
      end
      OP_LUI: begin
        // No register read: both operands become imm<<16, so OR yields it.
        dec_wreg      = 1'b1;
        dec_instvalid = 1'b1;
        dec_aluop     = EXE_OR_OP;
        dec_alusel    = EXE_RES_LOGIC;
        dec_wd        = rt;
        dec_imm       = DW'({imm16, 16'h0000});
      end
      OP_LW: begin
        dec_rd1       = 1'b1;
        dec_wreg      = 1'b1;
        dec_is_load   = 1'b1;
        dec_instvalid = 1'b1;
        dec_aluop     = EXE_LW_OP;
        dec_alusel    = EXE_RES_LOAD_STORE;
        dec_wd        = rt;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Regfile read port (quiet while in reset)
  // ---------------------------------------------------------------------------
  logic [1:0]    rd_en;
  logic [4:0]    rd_addr [2];
  logic [DW-1:0] rf_data [2];

  assign rd_en      = rst ? 2'b00 : {dec_rd2, dec_rd1};
  assign rd_addr[0] = rst ? 5'd0 : rs;
  assign rd_addr[1] = rst ? 5'd0 : rt;
  assign rf_data[0] = bus.reg1_data_i;
  assign rf_data[1] = bus.reg2_data_i;

  assign bus.reg1_read_o = rd_en[0];
  assign bus.reg2_read_o = rd_en[1];
  assign bus.reg1_addr_o = rd_addr[0];
  assign bus.reg2_addr_o = rd_addr[1];

  // ---------------------------------------------------------------------------
  // Bypass matching and operand selection
  // ---------------------------------------------------------------------------
  logic [1:0]    nz;
  logic [1:0]    ex_hit;
  logic [1:0]    mem_hit;
  logic [DW-1:0] opnd [2];

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      nz[p]      = (rd_addr[p] != 5'd0);
      ex_hit[p]  = rd_en[p] & bus.ex_wreg_i  & (bus.ex_wd_i  == rd_addr[p]);
      mem_hit[p] = rd_en[p] & bus.mem_wreg_i & (bus.mem_wd_i == rd_addr[p]);

      // $0 is hard-wired, so it is never bypassed even if a stage claims it.
      if (!rd_en[p])       opnd[p] = dec_imm;
      else if (!nz[p])     opnd[p] = '0;
      else if (ex_hit[p])  opnd[p] = bus.ex_wdata_i;
`ifdef ID_MEM_FWD_EN
      else if (mem_hit[p]) opnd[p] = bus.mem_wdata_i;
`endif
      else                 opnd[p] = rf_data[p];
    end
  end

  // ---------------------------------------------------------------------------
  // Hazard detection
  // ---------------------------------------------------------------------------
  logic load_use;
  logic mem_wait;
  logic stall;

  // A load in EX has no data yet; a dependent instruction must wait one cycle
  // and then picks the value up from MEM.
  assign load_use = bus.valid_i & bus.ex_is_load_i & |(ex_hit & nz);

`ifdef ID_MEM_FWD_EN
  assign mem_wait = 1'b0;
`else
  // Without a MEM bypass, wait one cycle until the write-through regfile
  // holds the value. A younger EX result shadows the MEM one.
  assign mem_wait = bus.valid_i & |(mem_hit & nz & ~ex_hit);
`endif

  // A flush wins over a stall: the instruction in ID is discarded anyway.
  assign stall           = ~rst & ~bus.flush_i & (load_use | mem_wait);
  assign bus.stall_req_o = stall;

  // ---------------------------------------------------------------------------
  // ID/EX register
  // ---------------------------------------------------------------------------
  id_ex_t id_ex_d;
  id_ex_t id_ex_q;

  always_comb begin
    id_ex_d = bubble();
    if (bus.valid_i && !bus.flush_i && !stall) begin
      id_ex_d.valid     = 1'b1;
      id_ex_d.wreg      = dec_wreg;
      id_ex_d.is_load   = dec_is_load;
      id_ex_d.instvalid = dec_instvalid;
      id_ex_d.aluop     = dec_aluop;
      id_ex_d.alusel    = dec_alusel;
      id_ex_d.reg1      = opnd[0];
      id_ex_d.reg2      = opnd[1];
      id_ex_d.wd        = dec_wd;
      id_ex_d.pc        = bus.pc_i;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) id_ex_q <= bubble();
    else     id_ex_q <= id_ex_d;
  end

  // Saturating count of hazard bubble cycles. stall is already low during
  // reset and flush, so those cycles are never counted.
  logic [CNTW-1:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt_q <= '0;
    else if (stall && (stall_cnt_q != {CNTW{1'b1}}))
      stall_cnt_q <= stall_cnt_q + 1'b1;
  end

  assign bus.ex_valid_o     = id_ex_q.valid;
  assign bus.ex_wreg_o      = id_ex_q.wreg;
  assign bus.ex_is_load_o   = id_ex_q.is_load;
  assign bus.ex_instvalid_o = id_ex_q.instvalid;
  assign bus.ex_aluop_o     = id_ex_q.aluop;
  assign bus.ex_alusel_o    = id_ex_q.alusel;
  assign bus.ex_reg1_o      = id_ex_q.reg1;
  assign bus.ex_reg2_o      = id_ex_q.reg2;
  assign bus.ex_wd_o        = id_ex_q.wd;
  assign bus.ex_pc_o        = id_ex_q.pc;
  assign bus.stall_cnt_o    = stall_cnt_q;

endmodule
